// File: rtl/rawrgb_pkg.sv
// rawrgb_pkg: shared constants for the RGB888 to RAW Bayer re-mosaic path.
// Holds the CFA pattern codes, the pixel phase encodings and the geometry counter width.
package rawrgb_pkg;
  localparam int CNT_W = 10;
  localparam logic [1:0] BAYER_BGGR = 2'd0;
  localparam logic [1:0] BAYER_GBRG = 2'd1;
  localparam logic [1:0] BAYER_GRBG = 2'd2;
  localparam logic [1:0] BAYER_RGGB = 2'd3;
  localparam logic [1:0] PH_B  = 2'b00;
  localparam logic [1:0] PH_G0 = 2'b01;
  localparam logic [1:0] PH_G1 = 2'b10;
  localparam logic [1:0] PH_R  = 2'b11;
endpackage

// File: rtl/rgb888_to_rawrgb_bayer_phase_counter.sv
// bayer_phase_counter: row/col tracking, Bayer phase, geometry checks and frame_done.
// Ports: clk, rst_n (async active-low), vsync/href (input syncs), err_clr (sync clear),
//        phase (combinational phase of the current input pixel), hlen_err/vlen_err (sticky),
//        frame_done (pulse two cycles after the vsync fall).
module bayer_phase_counter
  import rawrgb_pkg::*;
#(
  parameter logic [CNT_W-1:0] IMG_HDISP = 10'd640,
  parameter logic [CNT_W-1:0] IMG_VDISP = 10'd480,
  parameter logic [1:0]       BAYER_PAT = BAYER_BGGR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       href,
  input  logic       err_clr,
  output logic [1:0] phase,
  output logic       hlen_err,
  output logic       vlen_err,
  output logic       frame_done
);
  logic [CNT_W-1:0] row, col, row_c, col_c, row_inc, col_inc, lines_done;
  logic vs_d, hs_d, fd_d, vs_rise, vs_fall, hs_fall;
  assign vs_rise = vsync & ~vs_d;
  assign vs_fall = vs_d & ~vsync;
  assign hs_fall = hs_d & ~href;
  // A pixel arriving on the vsync rising edge already sees the cleared counters.
  assign row_c = vs_rise ? '0 : row;
  assign col_c = vs_rise ? '0 : col;
  assign row_inc = &row ? row : row + 1'b1;
  assign col_inc = &col_c ? col_c : col_c + 1'b1;
  // A line ending in the vsync-fall cycle still counts towards the frame.
  assign lines_done = hs_fall ? row_inc : row;
  assign phase = {row_c[0] ^ BAYER_PAT[1], col_c[0] ^ BAYER_PAT[0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      vs_d       <= 1'b0;
      hs_d       <= 1'b0;
      fd_d       <= 1'b0;
      frame_done <= 1'b0;
      hlen_err   <= 1'b0;
      vlen_err   <= 1'b0;
    end else begin
      vs_d       <= vsync;
      hs_d       <= href;
      row        <= vs_rise ? '0 : hs_fall ? row_inc : row;
      col        <= hs_fall ? '0 : href ? col_inc : col_c;
      hlen_err   <= (hlen_err & ~err_clr) | (hs_fall && col != IMG_HDISP);
      vlen_err   <= (vlen_err & ~err_clr) | (vs_fall && lines_done != IMG_VDISP);
      fd_d       <= vs_fall;
      frame_done <= fd_d;
    end
  end
endmodule

// File: rtl/rgb888_to_rawrgb.sv
// rgb888_to_rawrgb: re-mosaics an RGB888 stream into an 8-bit RAW Bayer stream.
// Ports: clk, rst_n (async active-low), per_frame_vsync/per_frame_href/per_img_* (RGB input),
//        err_clr, post_frame_vsync/post_frame_href/post_img_RAW (2-cycle delayed output),
//        frame_done, hlen_err, vlen_err.
module rgb888_to_rawrgb
  import rawrgb_pkg::*;
#(
  parameter logic [CNT_W-1:0] IMG_HDISP = 10'd640,
  parameter logic [CNT_W-1:0] IMG_VDISP = 10'd480,
  parameter logic [1:0]       BAYER_PAT = BAYER_BGGR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic [7:0] per_img_red,
  input  logic [7:0] per_img_green,
  input  logic [7:0] per_img_blue,
  input  logic       err_clr,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic [7:0] post_img_RAW,
  output logic       frame_done,
  output logic       hlen_err,
  output logic       vlen_err
);
  logic [1:0] phase, ph1;
  logic [7:0] r1, g1, b1, sample;
  logic       hs1, vs1;
  bayer_phase_counter #(
    .IMG_HDISP(IMG_HDISP),
    .IMG_VDISP(IMG_VDISP),
    .BAYER_PAT(BAYER_PAT)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (per_frame_vsync),
    .href      (per_frame_href),
    .err_clr   (err_clr),
    .phase     (phase),
    .hlen_err  (hlen_err),
    .vlen_err  (vlen_err),
    .frame_done(frame_done)
  );
  assign sample = ph1 == PH_R ? r1 : (ph1 == PH_G0 || ph1 == PH_G1) ? g1 : b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1               <= '0;
      g1               <= '0;
      b1               <= '0;
      ph1              <= PH_B;
      hs1              <= 1'b0;
      vs1              <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_img_RAW     <= '0;
    end else begin
      r1               <= per_img_red;
      g1               <= per_img_green;
      b1               <= per_img_blue;
      ph1              <= phase;
      hs1              <= per_frame_href;
      vs1              <= per_frame_vsync;
      post_frame_href  <= hs1;
      post_frame_vsync <= vs1;
      post_img_RAW     <= hs1 ? sample : 8'd0;
    end
  end
endmodule

// File: tb/tb_rgb888_to_rawrgb.sv
// tb_rgb888_to_rawrgb: directed self-checking bench, BGGR and RGGB instances on a 4x2 geometry.
module tb_rgb888_to_rawrgb;
  import rawrgb_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, href = 1'b0, err_clr = 1'b0;
  logic [7:0] red = 8'h11, green = 8'h22, blue = 8'h33;
  logic vs_a, hs_a, fd_a, he_a, ve_a, vs_b, hs_b, fd_b, he_b, ve_b;
  logic [7:0] raw_a, raw_b;
  logic [7:0] cap_a[$], cap_b[$];
  logic [7:0] exp_a[8] = '{8'h33, 8'h22, 8'h33, 8'h22, 8'h22, 8'h11, 8'h22, 8'h11};
  logic [7:0] exp_b[8] = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h22, 8'h33, 8'h22, 8'h33};
  int n_assert = 0, n_fail = 0;
  rgb888_to_rawrgb #(.IMG_HDISP(10'd4), .IMG_VDISP(10'd2), .BAYER_PAT(BAYER_BGGR)) dut_a (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_img_red(red), .per_img_green(green), .per_img_blue(blue), .err_clr(err_clr),
    .post_frame_vsync(vs_a), .post_frame_href(hs_a), .post_img_RAW(raw_a),
    .frame_done(fd_a), .hlen_err(he_a), .vlen_err(ve_a));
  rgb888_to_rawrgb #(.IMG_HDISP(10'd4), .IMG_VDISP(10'd2), .BAYER_PAT(BAYER_RGGB)) dut_b (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_img_red(red), .per_img_green(green), .per_img_blue(blue), .err_clr(err_clr),
    .post_frame_vsync(vs_b), .post_frame_href(hs_b), .post_img_RAW(raw_b),
    .frame_done(fd_b), .hlen_err(he_b), .vlen_err(ve_b));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (hs_a) cap_a.push_back(raw_a);
    if (hs_b) cap_b.push_back(raw_b);
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic lo(input int n);
    href = 1'b0;
    repeat (n) tick();
  endtask
  task automatic hi(input int n);
    href = 1'b1;
    repeat (n) tick();
  endtask
  task automatic frame(input int lines, input int first_len);
    vsync = 1'b1;
    lo(2);
    for (int i = 0; i < lines; i++) begin
      hi(i == 0 ? first_len : 4);
      lo(2);
    end
    vsync = 1'b0;
  endtask
  task automatic check_rows(input string tag);
    chk({tag, "_size_bggr"}, cap_a.size(), 8);
    chk({tag, "_size_rggb"}, cap_b.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_bggr[%0d]", tag, i), i < cap_a.size() ? cap_a[i] : 8'hxx, exp_a[i]);
      chk($sformatf("%s_rggb[%0d]", tag, i), i < cap_b.size() ? cap_b[i] : 8'hxx, exp_b[i]);
    end
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_vsync", vs_a, 0);
    chk("rst_href", hs_a, 0);
    chk("rst_raw", raw_a, 0);
    chk("rst_fd", fd_a, 0);
    chk("rst_hlen", he_a, 0);
    chk("rst_vlen", ve_a, 0);
    rst_n = 1'b1;
    tick();
    cap_a.delete();
    cap_b.delete();
    vsync = 1'b1;
    lo(2);
    href = 1'b1;
    tick();
    chk("lat_c1_href", hs_a, 0);
    tick();
    chk("lat_c2_href", hs_a, 1);
    chk("lat_c2_raw_bggr", raw_a, 8'h33);
    chk("lat_c2_raw_rggb", raw_b, 8'h11);
    tick();
    tick();
    lo(2);
    hi(4);
    lo(2);
    vsync = 1'b0;
    tick();
    chk("fd_edge_vsync", vs_a, 1);
    chk("fd_edge_pulse", fd_a, 0);
    tick();
    chk("fd_fall_vsync", vs_a, 0);
    chk("fd_fall_pulse", fd_a, 1);
    tick();
    chk("fd_after_pulse", fd_a, 0);
    chk("t1_hlen", he_a, 0);
    chk("t1_vlen", ve_a, 0);
    chk("idle_raw", raw_a, 0);
    check_rows("t1");
    lo(2);
    frame(2, 5);
    repeat (3) tick();
    chk("long_line_hlen", he_a, 1);
    chk("long_line_vlen", ve_a, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_hlen", he_a, 0);
    hi(3);
    err_clr = 1'b1;
    href = 1'b0;
    tick();
    err_clr = 1'b0;
    chk("set_wins_hlen", he_a, 1);
    tick();
    chk("sticky_hlen", he_a, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr2_hlen", he_a, 0);
    frame(3, 4);
    tick();
    chk("three_lines_vlen", ve_a, 1);
    chk("three_fd_edge", fd_a, 0);
    chk("three_vs_edge", vs_a, 1);
    tick();
    chk("three_fd_pulse", fd_a, 1);
    chk("three_vs_fall", vs_a, 0);
    tick();
    chk("three_fd_after1", fd_a, 0);
    tick();
    chk("three_fd_after2", fd_a, 0);
    chk("three_hlen", he_a, 0);
    vsync = 1'b1;
    lo(1);
    hi(3);
    #2;
    rst_n = 1'b0;
    href = 1'b0;
    vsync = 1'b0;
    #1;
    chk("abort_href", hs_a, 0);
    chk("abort_vsync", vs_a, 0);
    chk("abort_raw", raw_a, 0);
    chk("abort_vlen", ve_a, 0);
    chk("abort_fd", fd_a, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cap_a.delete();
    cap_b.delete();
    frame(2, 4);
    repeat (3) tick();
    check_rows("t4");
    chk("t4_hlen", he_a, 0);
    chk("t4_vlen", ve_a, 0);
    vsync = 1'b1;
    lo(2);
    hi(4);
    lo(2);
    hi(4);
    vsync = 1'b0;
    href = 1'b0;
    tick();
    chk("same_cycle_vlen", ve_a, 0);
    chk("same_cycle_hlen", he_a, 0);
    tick();
    chk("same_cycle_fd", fd_a, 1);
    lo(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
